// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam logic [4:0]  OP_HALT      = 5'b00000;
  localparam logic [4:0]  OP_NOP       = 5'b00001;
  localparam logic [15:0] BUBBLE_INSTR = 16'h0800;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    HALT  = 2'd2
  } fetch_state_e;

  function automatic logic [4:0] opcode_of(input logic [15:0] instr);
    return instr[15:11];
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory fetch bus: fetch stage is master, memory is slave.
interface fetch_if;
  logic [15:0] IMemAddr;
  logic        IMemReq;
  logic [15:0] IMemData;
  logic        IMemValid;

  modport master (output IMemAddr, IMemReq, input  IMemData, IMemValid);
  modport slave  (input  IMemAddr, IMemReq, output IMemData, IMemValid);
endinterface

// File: rtl/cla16b.sv
// 16-bit carry-lookahead adder, four 4-bit groups with group-level lookahead.
module cla16b (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic        cin_i,
  output logic [15:0] sum_o
);
  logic [15:0] g, p;
  logic [15:0] c;
  logic [3:0]  gg, gp;
  logic [4:0]  gc;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  for (genvar k = 0; k < 4; k++) begin : g_grp
    localparam int B = 4 * k;
    assign gg[k] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                 | (p[B+3] & p[B+2] & p[B+1] & g[B]);
    assign gp[k] = &p[B+3:B];
    assign c[B]   = gc[k];
    assign c[B+1] = g[B] | (p[B] & gc[k]);
    assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & gc[k]);
    assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                  | (p[B+2] & p[B+1] & p[B] & gc[k]);
  end

  assign gc[0] = cin_i;
  assign gc[1] = gg[0] | (gp[0] & gc[0]);
  assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & gc[0]);
  assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
               | (gp[2] & gp[1] & gp[0] & gc[0]);
  // Final carry out exists for completeness; PC math drops it.
  assign gc[4] = gg[3] | (gp[3] & gc[3]);

  assign sum_o = p ^ c;
endmodule

// File: rtl/fetch_hold_buf.sv
// 16-bit hold register with load/clear and a valid flag; clear wins over load.
module fetch_hold_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        clr_i,
  input  logic [15:0] d_i,
  output logic [15:0] q_o,
  output logic        vld_o
);
  logic [15:0] data_q;
  logic        vld_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= '0;
      vld_q  <= 1'b0;
    end else if (clr_i) begin
      data_q <= '0;
      vld_q  <= 1'b0;
    end else if (load_i) begin
      data_q <= d_i;
      vld_q  <= 1'b1;
    end
  end

  assign q_o   = data_q;
  assign vld_o = vld_q;
endmodule

// File: rtl/fetch_stage.sv
// IF stage + IF/ID register: PC, fetch handshake, hold buffer for stalls.
// Optional HALT state enabled by defining FETCH_HALT_EN.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic          clk,
  input  logic          rst,
  fetch_if.master       imem,
  input  logic          Redirect,
  input  logic [15:0]   RedirectPc,
  input  logic          PcStall,
  input  logic          NOP,
  output logic [15:0]   IfInstr,
  output logic          IfValid,
  output logic [15:0]   ID_Instr,
  output logic [15:0]   ID_PcPlus2,
  output logic          ID_Valid,
  output logic          Halted
);
  fetch_state_e state_q;
  logic [15:0]  pc_q, pc_d;
  logic [15:0]  id_instr_q, id_pcp2_q;
  logic         id_vld_q;

  logic [15:0]  hold_q;
  logic         hold_vld;
  logic         hold_load, hold_clr;
  logic         in_fetch, in_hold;
  logic         acc;
  logic [15:0]  acc_word;
  logic         acc_halt;

  cla16b u_pc_add (
    .a_i   (pc_q),
    .b_i   (16'h0002),
    .cin_i (1'b0),
    .sum_o (pc_d)
  );

  assign in_fetch = (state_q == FETCH);
  assign in_hold  = (state_q == HOLD);

  // Accept = word leaves IF this cycle, from memory or from the hold buffer.
  assign acc       = !Redirect && !PcStall && ((in_fetch && imem.IMemValid) || in_hold);
  assign acc_word  = in_hold ? hold_q : imem.IMemData;
  assign hold_load = !Redirect && in_fetch && imem.IMemValid && PcStall;
  assign hold_clr  = Redirect || (in_hold && !PcStall);

`ifdef FETCH_HALT_EN
  assign acc_halt = !NOP && (opcode_of(acc_word) == OP_HALT);
  assign Halted   = (state_q == HALT);
`else
  assign acc_halt = 1'b0;
  assign Halted   = 1'b0;
`endif

  fetch_hold_buf u_hold (
    .clk    (clk),
    .rst    (rst),
    .load_i (hold_load),
    .clr_i  (hold_clr),
    .d_i    (imem.IMemData),
    .q_o    (hold_q),
    .vld_o  (hold_vld)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      id_instr_q <= BUBBLE_INSTR;
      id_pcp2_q  <= '0;
      id_vld_q   <= 1'b0;
    end else if (Redirect) begin
      state_q    <= FETCH;
      pc_q       <= RedirectPc & 16'hFFFE;
      id_instr_q <= BUBBLE_INSTR;
      id_vld_q   <= 1'b0;
    end else if (acc) begin
      pc_q  <= pc_d;
      state_q <= acc_halt ? HALT : FETCH;
      // Shadow squash: PC still advances but ID gets a bubble.
      if (NOP) begin
        id_instr_q <= BUBBLE_INSTR;
        id_vld_q   <= 1'b0;
      end else begin
        id_instr_q <= acc_word;
        id_pcp2_q  <= pc_d;
        id_vld_q   <= 1'b1;
      end
    end else begin
      case (state_q)
        FETCH: begin
          if (imem.IMemValid) begin
            state_q <= HOLD;
            if (NOP) begin
              id_instr_q <= BUBBLE_INSTR;
              id_vld_q   <= 1'b0;
            end
          end else begin
            id_instr_q <= BUBBLE_INSTR;
            id_vld_q   <= 1'b0;
          end
        end
        HOLD: begin
          if (NOP) begin
            id_instr_q <= BUBBLE_INSTR;
            id_vld_q   <= 1'b0;
          end
        end
        default: begin
          id_instr_q <= BUBBLE_INSTR;
          id_vld_q   <= 1'b0;
        end
      endcase
    end
  end

  assign imem.IMemReq  = rst && in_fetch;
  assign imem.IMemAddr = pc_q;
  assign IfInstr       = in_hold ? hold_q : imem.IMemData;
  assign IfValid       = in_hold ? hold_vld : (in_fetch && imem.IMemValid);
  assign ID_Instr      = id_instr_q;
  assign ID_PcPlus2    = id_pcp2_q;
  assign ID_Valid      = id_vld_q;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; memory returns 16'h1000+addr (HALT word at 2 when armed).
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        Redirect = 1'b0;
  logic [15:0] RedirectPc = '0;
  logic        PcStall = 1'b0;
  logic        NOP = 1'b0;
  logic        mem_vld = 1'b0;
  logic        hlt_on = 1'b0;
  logic [15:0] IfInstr, ID_Instr, ID_PcPlus2;
  logic        IfValid, ID_Valid, Halted;
  int          n_vec = 0;
  int          n_err = 0;

  fetch_if imem ();

  assign imem.IMemValid = mem_vld;
  assign imem.IMemData  = (hlt_on && imem.IMemAddr == 16'h0002) ? 16'h0000
                                                                 : 16'h1000 + imem.IMemAddr;

  fetch_stage #(.RESET_PC(16'h0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem       (imem),
    .Redirect   (Redirect),
    .RedirectPc (RedirectPc),
    .PcStall    (PcStall),
    .NOP        (NOP),
    .IfInstr    (IfInstr),
    .IfValid    (IfValid),
    .ID_Instr   (ID_Instr),
    .ID_PcPlus2 (ID_PcPlus2),
    .ID_Valid   (ID_Valid),
    .Halted     (Halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_id(input string tag, input logic [15:0] ins, input logic [15:0] pcp2,
                        input logic vld);
    chk({tag, ".instr"}, ID_Instr, ins);
    if (vld) chk({tag, ".pcp2"}, ID_PcPlus2, pcp2);
    chk({tag, ".vld"}, {15'd0, ID_Valid}, {15'd0, vld});
  endtask

  initial begin
    #12;
    chk("rst.req", {15'd0, imem.IMemReq}, 16'd0);
    chk("rst.addr", imem.IMemAddr, 16'h0000);
    chk_id("rst", 16'h0800, 16'h0000, 1'b0);
    chk("rst.pcp2", ID_PcPlus2, 16'h0000);
    chk("rst.halted", {15'd0, Halted}, 16'd0);

    // Streaming fetch from reset
    rst = 1'b1; mem_vld = 1'b1;
    #1 chk("run.req", {15'd0, imem.IMemReq}, 16'd1);
    step(); chk_id("seq0", 16'h1000, 16'h0002, 1'b1);
    step(); chk_id("seq1", 16'h1002, 16'h0004, 1'b1);
    step(); chk_id("seq2", 16'h1004, 16'h0006, 1'b1);
    repeat (5) step();
    chk("pc10", imem.IMemAddr, 16'h0010);

    // Stall with NOP at PC=0x10 for 3 cycles
    PcStall = 1'b1; NOP = 1'b1;
    #1 chk("st.ifinstr0", IfInstr, 16'h1010);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_id("st.bub", 16'h0800, 16'h0000, 1'b0);
      chk("st.req", {15'd0, imem.IMemReq}, 16'd0);
      chk("st.ifinstr", IfInstr, 16'h1010);
      chk("st.ifvld", {15'd0, IfValid}, 16'd1);
    end
    PcStall = 1'b0; NOP = 1'b0;
    step(); chk_id("st.rel", 16'h1010, 16'h0012, 1'b1);
    chk("st.pc", imem.IMemAddr, 16'h0012);
    chk("st.req2", {15'd0, imem.IMemReq}, 16'd1);

    // Shadow squash at PC=0x20
    repeat (7) step();
    chk("pc20", imem.IMemAddr, 16'h0020);
    NOP = 1'b1;
    step(); chk_id("sq", 16'h0800, 16'h0000, 1'b0);
    chk("sq.pc", imem.IMemAddr, 16'h0022);
    NOP = 1'b0;
    step(); chk_id("n22", 16'h1022, 16'h0024, 1'b1);

    // Redirect out of HOLD
    PcStall = 1'b1;
    step(); chk_id("hold.keep", 16'h1022, 16'h0024, 1'b1);
    chk("hold.ifinstr", IfInstr, 16'h1024);
    Redirect = 1'b1; RedirectPc = 16'h0101;
    step(); chk_id("rd.bub", 16'h0800, 16'h0000, 1'b0);
    chk("rd.pc", imem.IMemAddr, 16'h0100);
    chk("rd.req", {15'd0, imem.IMemReq}, 16'd1);
    Redirect = 1'b0; PcStall = 1'b0;
    step(); chk_id("rd.fetch", 16'h1100, 16'h0102, 1'b1);

    // Redirect to the top of the address space: PC wraps
    Redirect = 1'b1; RedirectPc = 16'hFFFE;
    step(); chk("wr.pc", imem.IMemAddr, 16'hFFFE);
    Redirect = 1'b0;
    step(); chk_id("wr", 16'h0FFE, 16'h0000, 1'b1);
    chk("wr.pc2", imem.IMemAddr, 16'h0000);

    // No valid from memory: bubble, PC held
    mem_vld = 1'b0;
    #1 chk("nv.ifvld", {15'd0, IfValid}, 16'd0);
    step(); chk_id("nv", 16'h0800, 16'h0000, 1'b0);
    chk("nv.pc", imem.IMemAddr, 16'h0000);
    mem_vld = 1'b1;

    // HALT word at address 2
    hlt_on = 1'b1;
    step(); chk_id("h0", 16'h1000, 16'h0002, 1'b1);
    step(); chk_id("h1", 16'h0000, 16'h0004, 1'b1);
`ifdef FETCH_HALT_EN
    chk("h.halted", {15'd0, Halted}, 16'd1);
    chk("h.req", {15'd0, imem.IMemReq}, 16'd0);
    repeat (2) step();
    chk_id("h.bub", 16'h0800, 16'h0000, 1'b0);
    chk("h.pc", imem.IMemAddr, 16'h0004);
    chk("h.halted2", {15'd0, Halted}, 16'd1);
    Redirect = 1'b1; RedirectPc = 16'h0040;
    step(); Redirect = 1'b0;
    chk("h.out", {15'd0, Halted}, 16'd0);
    chk("h.pc2", imem.IMemAddr, 16'h0040);
`else
    chk("h.halted", {15'd0, Halted}, 16'd0);
    chk("h.req", {15'd0, imem.IMemReq}, 16'd1);
    step(); chk_id("h2", 16'h1004, 16'h0006, 1'b1);
`endif
    hlt_on = 1'b0;

    // Reset in the middle of a hold drops everything
    PcStall = 1'b1;
    step();
    chk("mr.req0", {15'd0, imem.IMemReq}, 16'd0);
    rst = 1'b0;
    #1 chk("mr.req", {15'd0, imem.IMemReq}, 16'd0);
    chk("mr.pc", imem.IMemAddr, 16'h0000);
    chk_id("mr", 16'h0800, 16'h0000, 1'b0);
    PcStall = 1'b0;
    @(negedge clk); rst = 1'b1;
    step(); chk_id("mr.run", 16'h1000, 16'h0002, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
